inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/rv32i_types.sv | 33 +++
 rtl/inst_queue.sv | 69 ++++++
 rtl/inst_fetch.sv | 115 +++++++++++
 tb/tb_inst_fetch.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: the IF/ID stage register, the fetch FSM state
// and the instruction-queue entry format.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
  } if_id_stage_reg_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } iq_entry_t;

  localparam logic [3:0] RMASK_WORD = 4'b1111;
  localparam logic [3:0] RMASK_NONE = 4'b0000;

endpackage

// File: rtl/inst_queue.sv
// Circular instruction queue with synchronous flush; the head entry is always
// presented combinationally and count tracks occupancy from 0 to DEPTH.
module inst_queue
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     enq,
  input  iq_entry_t                enq_data,
  input  logic                     deq,
  output iq_entry_t                head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  iq_entry_t       mem_q [DEPTH];
  iq_entry_t       mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [PW:0]     count_q, count_d;
  logic            do_enq, do_deq;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_deq  = deq && (count_q != '0);
    do_enq  = enq && (count_q != FULL_CNT);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_enq) begin
        mem_d[tail_q] = enq_data;
        tail_d        = tail_q + PW'(1);
      end
      if (do_deq) begin
        head_d = head_q + PW'(1);
      end
      // Pointers wrap naturally because DEPTH is a power of two.
      count_d = count_q + {{PW{1'b0}}, do_enq} - {{PW{1'b0}}, do_deq};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[head_q];
  assign count = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: single-outstanding imem request FSM, PC and dynamic
// order counter, feeding decode through an instruction queue.
module inst_fetch
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int unsigned IQ_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_addr,
  output logic [3:0]       imem_rmask,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_resp,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic [63:0]      redirect_order,
  input  logic             deq_ready,
  output if_id_stage_reg_t fetch_out,
  output fetch_state_t     dbg_state
);

  localparam int unsigned   CW        = $clog2(IQ_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(IQ_DEPTH);

  // Handshakes: a request is the single cycle imem_rmask is 4'b1111 and is
  // answered by exactly one imem_resp pulse in a later cycle; decode takes
  // the head when fetch_out.valid && deq_ready (valid never waits on ready).
  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [63:0]   order_q, order_d;
  logic          pending, slot_free, issue;
  logic          enq, deq, flush;
  logic [CW-1:0] iq_count;
  iq_entry_t     iq_head;
  iq_entry_t     enq_data;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    order_d   = order_q;
    issue     = 1'b0;
    enq       = 1'b0;
    flush     = 1'b0;
    pending   = (state_q != IDLE);
    // Reserve a slot for the in-flight word so the queue can never overflow.
    slot_free = (iq_count + CW'(pending)) < DEPTH_CNT;
    deq       = (iq_count != '0) && deq_ready && !redirect_valid;

    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = redirect_pc;
      order_d = redirect_order;
      state_d = (pending && !imem_resp) ? DISCARD : IDLE;
    end else begin
      if (pending && imem_resp) begin
        enq     = (state_q == WAIT);
        state_d = IDLE;
      end
      if (rst_n && (!pending || imem_resp) && slot_free) begin
        issue    = 1'b1;
        req_pc_d = pc_q;
        pc_d     = pc_q + 32'd4;
        state_d  = WAIT;
      end
      if (deq) begin
        order_d = order_q + 64'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      order_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      order_q  <= order_d;
    end
  end

  assign enq_data = '{inst: imem_rdata, pc: req_pc_q};

  inst_queue #(
    .DEPTH (IQ_DEPTH)
  ) u_iq (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .enq      (enq),
    .enq_data (enq_data),
    .deq      (deq),
    .head     (iq_head),
    .count    (iq_count)
  );

  assign imem_addr  = pc_q;
  assign imem_rmask = issue ? RMASK_WORD : RMASK_NONE;
  assign dbg_state  = state_q;

  always_comb begin
    fetch_out       = '0;
    fetch_out.valid = (iq_count != '0);
    fetch_out.inst  = iq_head.inst;
    fetch_out.pc    = iq_head.pc;
    fetch_out.order = order_q;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: a latency-configurable memory responder and
// a queue-based reference model of fetch order, redirect and back-pressure.
module tb_inst_fetch;
  import rv32i_types::*;

  localparam logic [31:0] RESET_PC = 32'h1eceb000;
  localparam int          DEPTH    = 8;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      imem_addr;
  logic [3:0]       imem_rmask;
  logic [31:0]      imem_rdata;
  logic             imem_resp;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [63:0]      redirect_order;
  logic             deq_ready;
  if_id_stage_reg_t fetch_out;
  fetch_state_t     dbg_state;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RESET_PC), .IQ_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_order (redirect_order),
    .deq_ready      (deq_ready),
    .fetch_out      (fetch_out),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];      // {inst, pc} in program order
  logic [31:0] exp_pc;
  logic [63:0] exp_order;
  logic        live;          // outstanding request will be kept
  logic [31:0] live_addr;
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat_min = 1;
  int          lat_max = 1;

  logic [3:0]       s_rmask;
  logic [31:0]      s_addr;
  if_id_stage_reg_t s_fo;
  fetch_state_t     s_state;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[31:16]};
  endfunction

  task automatic model_clear();
    exp_q.delete();
    exp_pc    = RESET_PC;
    exp_order = '0;
    live      = 1'b0;
    live_addr = '0;
    mem_busy  = 1'b0;
    mem_addr  = '0;
    mem_cnt   = 0;
  endtask

  task automatic idle_inputs();
    imem_resp      = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    redirect_order = '0;
    deq_ready      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock cycle: called at posedge+1, drives inputs, checks, returns at next posedge+1.
  task automatic cycle(input logic rd_v, input logic [31:0] rd_pc,
                       input logic [63:0] rd_ord, input logic dq);
    logic             out_before, resp, exp_issue, do_deq;
    logic [31:0]      rdata;
    int               qsz;
    fetch_state_t     exp_st;
    if_id_stage_reg_t exp_fo, fo;
    out_before = mem_busy;
    resp       = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        resp     = 1'b1;
        mem_busy = 1'b0;
      end
    end
    rdata          = resp ? word_at(mem_addr) : $urandom();
    imem_resp      = resp;
    imem_rdata     = rdata;
    redirect_valid = rd_v;
    redirect_pc    = rd_v ? rd_pc : $urandom();
    redirect_order = rd_v ? rd_ord : {$urandom(), $urandom()};
    deq_ready      = dq;
    #1;
    s_rmask = imem_rmask;
    s_addr  = imem_addr;
    s_fo    = fetch_out;
    s_state = dbg_state;

    qsz       = exp_q.size();
    exp_st    = !out_before ? IDLE : (live ? WAIT : DISCARD);
    exp_issue = !rd_v && (!out_before || resp) && ((qsz + (out_before ? 1 : 0)) < DEPTH);
    exp_fo       = '0;
    exp_fo.valid = (qsz != 0);
    exp_fo.order = exp_order;
    if (qsz != 0) begin
      exp_fo.inst = exp_q[0][63:32];
      exp_fo.pc   = exp_q[0][31:0];
    end
    fo = fetch_out;
    if (!fo.valid) begin
      fo.inst = '0;
      fo.pc   = '0;
    end

    n_checks++;
    if (s_state !== exp_st) begin
      n_errors++;
      $display("FAIL state: got %0d expected %0d at %0t", s_state, exp_st, $time);
    end
    n_checks++;
    if (s_rmask !== (exp_issue ? 4'hf : 4'h0)) begin
      n_errors++;
      $display("FAIL rmask: got %h expected %h at %0t", s_rmask, exp_issue ? 4'hf : 4'h0, $time);
    end
    n_checks++;
    if (s_addr !== exp_pc) begin
      n_errors++;
      $display("FAIL imem_addr: got %h expected %h at %0t", s_addr, exp_pc, $time);
    end
    n_checks++;
    if (fo !== exp_fo) begin
      n_errors++;
      $display("FAIL fetch_out: got %h expected %h at %0t", fo, exp_fo, $time);
    end

    // Reference update for the coming edge.
    do_deq = !rd_v && dq && (qsz != 0);
    if (rd_v) begin
      exp_q.delete();
      exp_pc    = rd_pc;
      exp_order = rd_ord;
      live      = 1'b0;
    end else begin
      if (do_deq) begin
        void'(exp_q.pop_front());
        exp_order = exp_order + 64'd1;
      end
      if (resp && live) exp_q.push_back({rdata, live_addr});
      if (resp) live = 1'b0;
      if (exp_issue) begin
        live      = 1'b1;
        live_addr = exp_pc;
        exp_pc    = exp_pc + 32'd4;
      end
    end

    // Memory side follows what the DUT actually requested.
    if (s_rmask == 4'hf) begin
      n_checks++;
      if (mem_busy) begin
        n_errors++;
        $display("FAIL one_outstanding: got second request at %h expected none at %0t", s_addr, $time);
      end
      mem_busy = 1'b1;
      mem_addr = s_addr;
      mem_cnt  = $urandom_range(lat_max, lat_min);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    imem_resp = 1'b1;
    deq_ready = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (fetch_out !== '0) begin
      n_errors++;
      $display("FAIL reset_fetch_out: got %h expected 0", fetch_out);
    end
    n_checks++;
    if (imem_rmask !== 4'h0) begin
      n_errors++;
      $display("FAIL reset_rmask: got %h expected 0", imem_rmask);
    end
    n_checks++;
    if (imem_addr !== RESET_PC) begin
      n_errors++;
      $display("FAIL reset_addr: got %h expected %h", imem_addr, RESET_PC);
    end
    n_checks++;
    if (dbg_state !== IDLE) begin
      n_errors++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    do_reset();
    lat_min = 1;
    lat_max = 1;
    for (int k = 0; k < 16; k++) begin
      cycle(1'b0, '0, '0, 1'b1);
      n_checks++;
      if (s_rmask !== 4'hf || s_addr !== RESET_PC + 32'(4 * k)) begin
        n_errors++;
        $display("FAIL stream_req: got %h/%h expected f/%h", s_rmask, s_addr, RESET_PC + 32'(4 * k));
      end
      n_checks++;
      if (k < 2) begin
        if (s_fo.valid !== 1'b0) begin
          n_errors++;
          $display("FAIL stream_early_valid: got %b expected 0 at k=%0d", s_fo.valid, k);
        end
      end else if (s_fo.valid !== 1'b1 || s_fo.pc !== RESET_PC + 32'(4 * (k - 2)) ||
                   s_fo.order !== 64'(k - 2)) begin
        n_errors++;
        $display("FAIL stream_out: got v=%b pc=%h ord=%0d expected v=1 pc=%h ord=%0d",
                 s_fo.valid, s_fo.pc, s_fo.order, RESET_PC + 32'(4 * (k - 2)), k - 2);
      end
    end
  endtask

  task automatic test_backpressure();
    int n_req;
    do_reset();
    lat_min = 1;
    lat_max = 1;
    n_req   = 0;
    for (int k = 0; k < 14; k++) begin
      cycle(1'b0, '0, '0, 1'b0);
      if (s_rmask == 4'hf) n_req++;
    end
    n_checks++;
    if (n_req != DEPTH) begin
      n_errors++;
      $display("FAIL bp_request_count: got %0d expected %0d", n_req, DEPTH);
    end
    cycle(1'b0, '0, '0, 1'b1);
    n_checks++;
    if (s_rmask !== 4'h0 || s_fo.valid !== 1'b1 || s_fo.pc !== RESET_PC || s_fo.order !== 64'd0) begin
      n_errors++;
      $display("FAIL bp_deq: got rmask=%h v=%b pc=%h ord=%0d expected 0/1/%h/0",
               s_rmask, s_fo.valid, s_fo.pc, s_fo.order, RESET_PC);
    end
    cycle(1'b0, '0, '0, 1'b0);
    n_checks++;
    if (s_rmask !== 4'hf || s_addr !== RESET_PC + 32'd32) begin
      n_errors++;
      $display("FAIL bp_resume: got %h/%h expected f/%h", s_rmask, s_addr, RESET_PC + 32'd32);
    end
  endtask

  task automatic test_redirect_wait();
    logic found;
    do_reset();
    lat_min = 3;
    lat_max = 3;
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b1, 32'h1eceb100, 64'd40, 1'b1);
    n_checks++;
    if (s_state !== WAIT) begin
      n_errors++;
      $display("FAIL redir_wait_state: got %0d expected %0d", s_state, WAIT);
    end
    cycle(1'b0, '0, '0, 1'b0);
    n_checks++;
    if (s_state !== DISCARD) begin
      n_errors++;
      $display("FAIL redir_discard_state: got %0d expected %0d", s_state, DISCARD);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b0, '0, '0, 1'b0);
      if (s_fo.valid) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL redir_wait_timeout: got no valid expected valid within 20 cycles");
    end else if (s_fo.pc !== 32'h1eceb100 || s_fo.order !== 64'd40 ||
                 s_fo.inst !== word_at(32'h1eceb100)) begin
      n_errors++;
      $display("FAIL redir_wait_out: got pc=%h ord=%0d inst=%h expected 1eceb100/40/%h",
               s_fo.pc, s_fo.order, s_fo.inst, word_at(32'h1eceb100));
    end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    lat_min = 1;
    lat_max = 1;
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b1, 32'h1eceb200, 64'd7, 1'b1);
    n_checks++;
    if (imem_resp !== 1'b1 || s_rmask !== 4'h0) begin
      n_errors++;
      $display("FAIL redir_same_setup: got resp=%b rmask=%h expected 1/0", imem_resp, s_rmask);
    end
    cycle(1'b0, '0, '0, 1'b1);
    n_checks++;
    if (s_state !== IDLE || s_rmask !== 4'hf || s_addr !== 32'h1eceb200 || s_fo.valid !== 1'b0) begin
      n_errors++;
      $display("FAIL redir_same_next: got st=%0d rmask=%h addr=%h v=%b expected IDLE/f/1eceb200/0",
               s_state, s_rmask, s_addr, s_fo.valid);
    end
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);
    n_checks++;
    if (s_fo.valid !== 1'b1 || s_fo.pc !== 32'h1eceb200 || s_fo.order !== 64'd7) begin
      n_errors++;
      $display("FAIL redir_same_out: got v=%b pc=%h ord=%0d expected 1/1eceb200/7",
               s_fo.valid, s_fo.pc, s_fo.order);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat_min = 1;
    lat_max = 1;
    for (int k = 0; k < 6; k++) cycle(1'b0, '0, '0, 1'b0);
    n_checks++;
    if (fetch_out.valid !== 1'b1 || dbg_state !== WAIT) begin
      n_errors++;
      $display("FAIL mid_setup: got v=%b st=%0d expected 1/%0d", fetch_out.valid, dbg_state, WAIT);
    end
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (fetch_out !== '0 || imem_rmask !== 4'h0 || dbg_state !== IDLE) begin
      n_errors++;
      $display("FAIL mid_async: got fo=%h rmask=%h st=%0d expected 0/0/IDLE",
               fetch_out, imem_rmask, dbg_state);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    cycle(1'b0, '0, '0, 1'b1);
    n_checks++;
    if (s_rmask !== 4'hf || s_addr !== RESET_PC) begin
      n_errors++;
      $display("FAIL mid_restart: got %h/%h expected f/%h", s_rmask, s_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic        rd;
    logic        dq;
    logic [31:0] rpc;
    logic [63:0] rord;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if (k % 100 == 0) begin
        lat_min = 1;
        lat_max = $urandom_range(3, 1);
      end
      rd   = ($urandom_range(99, 0) < 4);
      dq   = ($urandom_range(99, 0) < 70);
      rpc  = $urandom() & 32'hffff_fffc;
      rord = {$urandom(), $urandom()};
      cycle(rd, rpc, rord, dq);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
